div_unit: RTL
=============

Name: div_unit

Overview:
- Iterative radix-2 divider for the EX stage, handling MIPS DIV and DIVU.
- Sits beside the combinational ALU and is the multi-cycle responder to the EX-stage issue handshake.
- Returns remainder into HI and quotient into LO.
- Holds the pipeline through a stall output until the result is ready.

Parameters:
- DATA_W, 32, operand width. Quotient and remainder are each DATA_W; the result is 2*DATA_W.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- a  in  DATA_W  dividend (rs)
- b  in  DATA_W  divisor (rt)
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
- start  in  1  issue request from EX; sampled only in IDLE
- annul  in  1  flush/exception; aborts the operation in flight
- stall  out  1  hold IF/ID/EX while the divide is in progress
- ready  out  1  one-cycle pulse: result is valid
- result  out  2*DATA_W  {remainder[hi], quotient[lo]}

Behaviour:
- Reset (async, rst=1): state=IDLE, counter=0, ready=0, result=0. The internal dividend/divisor/partial-remainder registers are cleared.
- States: IDLE, ON, DONE.
  - IDLE:
    - start=1, annul=0, b!=0: latch |a| and |b| (abs only if signed_div), plus the sign of a and the sign of (a^b), counter=0 -> ON.
    - start=1, annul=0, b==0: -> DONE with quotient=all-ones, remainder=a.
    - Otherwise stay in IDLE. start is ignored in every other state.
  - ON:
    - One restoring-division iteration per edge: shift {rem,quot} left 1; trial subtract divisor; if non-negative keep it and set quot LSB=1.
    - counter increments each edge; after the DATA_W-th iteration -> DONE.
  - DONE:
    - ready=1 for exactly this cycle; result is held stable.
    - -> IDLE on the next edge.
- Sign fix (signed_div=1), applied when entering DONE:
  - quotient negated if the operand signs differ;
  - remainder negated if the dividend was negative.
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0 (natural wrap, no trap).
- Latency: start sampled at edge E0; iterations at E1..E32; ready high in the cycle following E32 (33 cycles after start edge for DATA_W=32). Divide-by-zero has a 1-cycle latency.
- stall = (IDLE & start & ~annul) | ON. It is combinational, so the issuing instruction stalls in the same cycle it asserts start. stall is low in DONE so the pipeline advances while ready=1.
- annul:
  - In any state, annul=1 forces -> IDLE on the next edge.
  - ready is not asserted and result is not updated.
  - annul and start together in IDLE: annul wins, no operation starts.
  - annul in DONE: ready still pulses in that cycle (already committed); the state then returns to IDLE normally.
- result keeps its last value until the next DONE. ready is a pulse and never stays high.
- Reset mid-operation: immediate return to IDLE; stall and ready drop asynchronously.

Decomposition:
- Shared package/header entries:
  - state encodings DIV_IDLE, DIV_ON, DIV_DONE (2-bit);
  - the DIV/DIVU op codes alongside the existing ALU control defines.
- One natural sub-module: div_iter, the combinational single-step shift/trial-subtract, instantiated once.
- Sign handling and the FSM stay in div_unit.

Test Plan:
- DIVU 100/7: a=0x64, b=0x7, start pulse -> stall high 33 cycles from start; ready at cycle 33; result={0x00000002, 0x0000000E}.
- DIV signed -7/2: a=0xFFFFFFF9, b=0x2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1).
- Signed overflow corner: a=0x80000000, b=0xFFFFFFFF, signed_div=1 -> result={0x00000000, 0x80000000}, no hang.
- Divide by zero: a=0x12345678, b=0 -> ready one cycle after start; result={0x12345678, 0xFFFFFFFF}; stall high only in the start cycle.
- Annul mid-divide: start 50/5, assert annul at cycle 10 -> IDLE next edge, no ready pulse, result unchanged. A new start 9/3 then completes with {0x0, 0x3}.
- Async reset asserted at cycle 20 of a divide, plus start held high during ON -> state IDLE, stall/ready 0 immediately; a start held high during ON causes no restart.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared definitions for the EX-stage divider: FSM encodings and ALU op codes.
package div_unit_pkg;

    // Divider control states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_ON   = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // ALU control codes; DIV/DIVU route the operation to the divider
    localparam logic [3:0] ALU_OP_ADD  = 4'd0;
    localparam logic [3:0] ALU_OP_SUB  = 4'd1;
    localparam logic [3:0] ALU_OP_AND  = 4'd2;
    localparam logic [3:0] ALU_OP_OR   = 4'd3;
    localparam logic [3:0] ALU_OP_XOR  = 4'd4;
    localparam logic [3:0] ALU_OP_SLT  = 4'd5;
    localparam logic [3:0] ALU_OP_DIV  = 4'd8;
    localparam logic [3:0] ALU_OP_DIVU = 4'd9;

endpackage

// File: rtl/div_unit_iter.sv
// One restoring-division step: shift {rem,quot} left, trial-subtract the divisor.
module div_iter #(
    parameter int unsigned W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quot_i,
    input  logic [W-1:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quot_o
);

    // Shifted remainder needs W+1 bits: it can reach 2*divisor-1 for large divisors
    logic [W:0] rem_sh;
    logic [W:0] diff;

    // Trial subtract; keep the difference when it did not borrow
    always_comb begin
        rem_sh = {rem_i, quot_i[W-1]};
        diff   = rem_sh - {1'b0, divisor_i};
        if (!diff[W]) begin
            rem_o = diff[W-1:0];
        end else begin
            rem_o = rem_sh[W-1:0];
        end
        quot_o = {quot_i[W-2:0], ~diff[W]};
    end

endmodule

// File: rtl/div_unit.sv
// Iterative radix-2 divider for MIPS DIV/DIVU. Result is {remainder, quotient}.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   a,
    input  logic [DATA_W-1:0]   b,
    input  logic                signed_div,
    input  logic                start,
    input  logic                annul,
    output logic                stall,
    output logic                ready,
    output logic [2*DATA_W-1:0] result
);

    localparam int unsigned CNT_W = $clog2(DATA_W);

    div_state_e state_q, state_d;

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rem_q, rem_d;
    logic [DATA_W-1:0]   quot_q, quot_d;
    logic [DATA_W-1:0]   dvsr_q, dvsr_d;
    logic                qneg_q, qneg_d;
    logic                rneg_q, rneg_d;
    logic [2*DATA_W-1:0] result_q, result_d;

    logic [DATA_W-1:0] iter_rem, iter_quot;
    logic [DATA_W-1:0] fix_rem, fix_quot;
    logic [DATA_W-1:0] abs_a, abs_b;
    logic              go, last;

    assign go   = start & ~annul;
    assign last = (cnt_q == CNT_W'(DATA_W - 1));

    div_iter #(
        .W (DATA_W)
    ) u_iter (
        .rem_i     (rem_q),
        .quot_i    (quot_q),
        .divisor_i (dvsr_q),
        .rem_o     (iter_rem),
        .quot_o    (iter_quot)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= DIV_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; annul always wins and returns to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (go) begin
                    state_d = (b == '0) ? DIV_DONE : DIV_ON;
                end
            end
            DIV_ON: begin
                if (annul) begin
                    state_d = DIV_IDLE;
                end else if (last) begin
                    state_d = DIV_DONE;
                end
            end
            default: state_d = DIV_IDLE;
        endcase
    end

    // Outputs; gated by rst so they drop as soon as reset asserts
    always_comb begin
        stall = ~rst & (((state_q == DIV_IDLE) & go) | (state_q == DIV_ON));
        ready = ~rst & (state_q == DIV_DONE);
    end

    // Operand magnitudes and final sign correction
    always_comb begin
        abs_a    = (signed_div && a[DATA_W-1]) ? -a : a;
        abs_b    = (signed_div && b[DATA_W-1]) ? -b : b;
        fix_rem  = rneg_q ? -iter_rem : iter_rem;
        fix_quot = qneg_q ? -iter_quot : iter_quot;
    end

    // Datapath next-state: operand latch, iteration, result capture
    always_comb begin
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quot_d   = quot_q;
        dvsr_d   = dvsr_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        result_d = result_q;
        unique case (state_q)
            DIV_IDLE: begin
                if (go) begin
                    if (b == '0) begin
                        result_d = {a, {DATA_W{1'b1}}};
                    end else begin
                        cnt_d  = '0;
                        rem_d  = '0;
                        quot_d = abs_a;
                        dvsr_d = abs_b;
                        qneg_d = signed_div & (a[DATA_W-1] ^ b[DATA_W-1]);
                        rneg_d = signed_div & a[DATA_W-1];
                    end
                end
            end
            DIV_ON: begin
                if (!annul) begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    rem_d  = iter_rem;
                    quot_d = iter_quot;
                    if (last) begin
                        result_d = {fix_rem, fix_quot};
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            dvsr_q   <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            quot_q   <= quot_d;
            dvsr_q   <= dvsr_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule
